clocked_srff_bank: RTL



---
 rtl/clocked_srff_bank.sv | 128 ++++++++++++
 1 files changed

// File: rtl/clocked_srff_bank.sv
// Bank of N clocked SR flip-flops, synchronous to CLK, driven by a filtered emulated TTL clock CLK_N.
// Optional sticky S=R=1 conflict flags are built only when SRFF_BANK_CONFLICT_EN is defined.
module clocked_srff_bank #(
    parameter int             N         = 1,
    parameter int             MODE      = 0,
    parameter int             FILT      = 0,
    parameter int             SR_BOTH   = 0,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CLK_N,
    input  logic [N-1:0] PRE_N,
    input  logic [N-1:0] CLR_N,
    input  logic [N-1:0] S,
    input  logic [N-1:0] R,
    input  logic         CONFLICT_CLR,
    output logic [N-1:0] Q,
    output logic [N-1:0] Q_N,
    output logic [N-1:0] CONFLICT
);

    logic         ck_f;
    logic         ck_d;
    logic         fall;
    logic         active;
    logic [N-1:0] q_next;

    function automatic logic next_bit(input logic q, input logic pre_n, input logic clr_n,
                                      input logic s, input logic r, input logic act);
        logic nb;
        nb = q;
        if (!pre_n)
            nb = 1'b1;
        else if (!clr_n)
            nb = 1'b0;
        else if (act && s && !r)
            nb = 1'b1;
        else if (act && !s && r)
            nb = 1'b0;
        else if (act && s && r) begin
            case (SR_BOTH)
                1:       nb = 1'b1;
                2:       nb = 1'b0;
                3:       nb = ~q;
                default: nb = q;
            endcase
        end
        return nb;
    endfunction

    generate
        if (FILT == 0) begin : g_nofilt
            assign ck_f = CLK_N;
        end else begin : g_filt
            localparam int            CW   = $clog2(FILT + 1);
            localparam logic [CW-1:0] LAST = CW'(FILT - 1);
            logic [CW-1:0] cnt;
            logic          ck_r;

            // A change is accepted only after FILT consecutive mismatching samples.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    ck_r <= 1'b1;
                    cnt  <= '0;
                end else if (CLK_N != ck_r) begin
                    if (cnt == LAST) begin
                        ck_r <= CLK_N;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end

            assign ck_f = ck_r;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            ck_d <= 1'b1;
        else
            ck_d <= ck_f;
    end

    assign fall   = ck_d & ~ck_f;
    assign active = (MODE == 0) ? ~ck_f : fall;

    always_comb begin
        q_next = Q;
        for (int i = 0; i < N; i++)
            q_next[i] = next_bit(Q[i], PRE_N[i], CLR_N[i], S[i], R[i], active);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            Q <= RESET_VAL;
        else
            Q <= q_next;
    end

    assign Q_N = ~Q;

`ifdef SRFF_BANK_CONFLICT_EN
    logic [N-1:0] conflict_r;
    logic [N-1:0] conflict_hit;

    assign conflict_hit = {N{active}} & S & R & PRE_N & CLR_N;

    // A new conflict in the same cycle as CONFLICT_CLR keeps its flag set.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            conflict_r <= '0;
        else
            conflict_r <= (CONFLICT_CLR ? '0 : conflict_r) | conflict_hit;
    end

    assign CONFLICT = conflict_r;
`else
    logic unused_conflict_clr;
    assign unused_conflict_clr = CONFLICT_CLR;
    assign CONFLICT            = '0;
`endif

endmodule
